// File: rtl/cpmg_pkg.sv
// rtl/cpmg_pkg.sv - shared state, phase and mode definitions for the CPMG sequencer
package cpmg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    P90   = 3'd2,
    WAIT1 = 3'd3,
    P180  = 3'd4,
    WAIT2 = 3'd5,
    TAIL  = 3'd6
  } state_t;

  localparam logic PH_X      = 1'b0;
  localparam logic PH_Y      = 1'b1;
  localparam logic MODE_CP   = 1'b0;
  localparam logic MODE_CPMG = 1'b1;

  // Receive windows: the only states where the ADC gate may open.
  function automatic logic is_wait(input state_t s);
    return (s == WAIT1) || (s == WAIT2) || (s == TAIL);
  endfunction

endpackage

// File: rtl/cpmg_timer.sv
// rtl/cpmg_timer.sv - loadable saturating down-counter used for state and blanking timing
module cpmg_timer #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expire
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - ONE;
    end
  end

  assign expire = (value == '0);

endmodule

// File: rtl/cpmg_seq.sv
// rtl/cpmg_seq.sv - CP/CPMG pulse-train generator driving DDS amplitude, RF phase and receiver gate
module cpmg_seq
  import cpmg_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                CNT_W      = 32,
  parameter int                ECHO_W     = 16,
  parameter logic [DATA_W-1:0] HIGH_VALUE = 16'h7FF8,
  parameter logic [DATA_W-1:0] LOW_VALUE  = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [CNT_W-1:0]  delay_reg,
  input  logic [CNT_W-1:0]  tau,
  input  logic [CNT_W-1:0]  tau_l,
  input  logic [ECHO_W-1:0] n_echo,
  input  logic [CNT_W-1:0]  blank_cyc,
  output logic [DATA_W-1:0] data,
  output logic              phase,
  output logic              rx_gate,
  output logic [ECHO_W-1:0] echo_idx,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int              TW       = CNT_W + 1;
  localparam logic [TW-1:0]   T_ONE    = TW'(1);
  localparam logic [ECHO_W-1:0] E_ONE  = ECHO_W'(1);

  state_t             st, ns;
  logic [CNT_W-1:0]   tau_q, taul_q, blank_q;
  logic [ECHO_W-1:0]  nech_q;
  logic               mode_q;

  logic               t_ld, t_exp, b_ld, b_exp;
  logic [TW-1:0]      t_lv, b_val, t_val_unused;
  logic               cfg_ok, accept;

  assign cfg_ok = (tau != '0) && (tau_l != '0) && (n_echo != '0);
  assign accept = (st == IDLE) && start && !abort && cfg_ok;

  // Timer holds "cycles remaining after this one"; expire marks the last cycle of a state.
  // The accept cycle counts toward DELAY, so DELAY loads delay_reg rather than delay_reg-1.
  always_comb begin
    ns   = st;
    t_ld = 1'b0;
    t_lv = '0;
    case (st)
      IDLE:  if (accept) begin
               ns = DELAY; t_ld = 1'b1; t_lv = {1'b0, delay_reg};
             end
      DELAY: if (t_exp) begin
               ns = P90; t_ld = 1'b1; t_lv = {1'b0, tau_q} - T_ONE;
             end
      P90:   if (t_exp) begin
               ns = WAIT1; t_ld = 1'b1; t_lv = {1'b0, taul_q} - T_ONE;
             end
      WAIT1, WAIT2:
             if (t_exp) begin
               ns = P180; t_ld = 1'b1; t_lv = {tau_q, 1'b0} - T_ONE;
             end
      P180:  if (t_exp) begin
               t_ld = 1'b1;
               if (echo_idx < nech_q) begin
                 ns = WAIT2; t_lv = {taul_q, 1'b0} - T_ONE;
               end else begin
                 ns = TAIL; t_lv = {1'b0, taul_q} - T_ONE;
               end
             end
      TAIL:  if (t_exp) ns = IDLE;
      default: ns = IDLE;
    endcase
    if (abort) ns = IDLE;
  end

  assign b_ld = t_ld && is_wait(ns);

  cpmg_timer #(.W(TW)) u_state_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_ld),
    .load_val (t_lv),
    .value    (t_val_unused),
    .expire   (t_exp)
  );

  cpmg_timer #(.W(TW)) u_blank_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (b_ld),
    .load_val ({1'b0, blank_q}),
    .value    (b_val),
    .expire   (b_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= IDLE;
      data     <= LOW_VALUE;
      phase    <= PH_X;
      rx_gate  <= 1'b0;
      echo_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      tau_q    <= '0;
      taul_q   <= '0;
      blank_q  <= '0;
      nech_q   <= '0;
      mode_q   <= MODE_CP;
    end else begin
      st      <= ns;
      data    <= (ns == P90 || ns == P180) ? HIGH_VALUE : LOW_VALUE;
      phase   <= (ns == P180) ? mode_q : PH_X;
      busy    <= (ns != IDLE);
      done    <= !abort && (st == TAIL) && t_exp;
      cfg_err <= (st == IDLE) && start && !abort && !cfg_ok;
      // Gate opens once the blank counter has drained; it is reloaded on every window entry.
      rx_gate <= is_wait(ns) && (b_ld ? (blank_q == '0) : (b_exp || b_val == T_ONE));
      if (abort || accept)
        echo_idx <= '0;
      else if (ns == P180 && st != P180)
        echo_idx <= echo_idx + E_ONE;
      if (accept) begin
        tau_q   <= tau;
        taul_q  <= tau_l;
        blank_q <= blank_cyc;
        nech_q  <= n_echo;
        mode_q  <= mode;
      end
    end
  end

endmodule

// File: tb/tb_cpmg_seq.sv
// tb/tb_cpmg_seq.sv - randomized self-checking bench for cpmg_seq against a segment-list model
module tb_cpmg_seq;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 32;
  localparam int ECHO_W = 16;
  localparam int HIGH   = 'h7FF8;
  localparam int LOW    = 0;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              mode = 1'b0;
  logic [CNT_W-1:0]  delay_reg = '0;
  logic [CNT_W-1:0]  tau = '0;
  logic [CNT_W-1:0]  tau_l = '0;
  logic [ECHO_W-1:0] n_echo = '0;
  logic [CNT_W-1:0]  blank_cyc = '0;
  logic [DATA_W-1:0] data;
  logic              phase;
  logic              rx_gate;
  logic [ECHO_W-1:0] echo_idx;
  logic              busy;
  logic              done;
  logic              cfg_err;

  cpmg_seq #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .ECHO_W(ECHO_W),
    .HIGH_VALUE(16'h7FF8), .LOW_VALUE(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .delay_reg(delay_reg), .tau(tau), .tau_l(tau_l), .n_echo(n_echo),
    .blank_cyc(blank_cyc), .data(data), .phase(phase), .rx_gate(rx_gate),
    .echo_idx(echo_idx), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #4 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected per-cycle outputs, index 0 = cycle registered at the start edge.
  int q_data[$], q_ph[$], q_rx[$], q_echo[$], q_busy[$], q_done[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // kind: 0 delay, 1 90-pulse, 2 180-pulse, 3 receive window
  task automatic add_seg(input int kind, input int len, input int echo, input int m, input int b);
    for (int j = 0; j < len; j++) begin
      q_data.push_back((kind == 1 || kind == 2) ? HIGH : LOW);
      q_ph.push_back(kind == 2 ? m : 0);
      q_rx.push_back((kind == 3 && j >= b) ? 1 : 0);
      q_echo.push_back(echo);
      q_busy.push_back(1);
      q_done.push_back(0);
    end
  endtask

  task automatic build_model(input int d, input int t, input int tl, input int n,
                             input int m, input int b);
    q_data.delete(); q_ph.delete(); q_rx.delete();
    q_echo.delete(); q_busy.delete(); q_done.delete();
    add_seg(0, d + 1, 0, m, b);
    add_seg(1, t, 0, m, b);
    add_seg(3, tl, 0, m, b);
    for (int i = 1; i <= n; i++) begin
      add_seg(2, 2 * t, i, m, b);
      add_seg(3, (i < n) ? 2 * tl : tl, i, m, b);
    end
    q_data.push_back(LOW); q_ph.push_back(0); q_rx.push_back(0);
    q_echo.push_back(n); q_busy.push_back(0); q_done.push_back(1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_data"}, 64'(data), 64'(LOW));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_echo"}, 64'(echo_idx), 64'd0);
    check({tag, "_rx"}, 64'(rx_gate), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic run_seq(input int d, input int t, input int tl, input int n, input int m,
                         input int b, input int abort_at, input int rst_at, input bit noise);
    int sz;
    build_model(d, t, tl, n, m, b);
    sz = q_data.size();
    delay_reg = d; tau = t; tau_l = tl; n_echo = n; mode = m; blank_cyc = b;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int e = 0; e < sz; e++) begin
      if (e == abort_at) begin
        abort = 1'b0;
        check_idle("abort");
        tick;
        check("abort_nodone", 64'(done), 64'd0);
        return;
      end
      if (e == rst_at) begin
        #2 rst = 1'b0;
        #1;
        check_idle("rst");
        check("rst_phase", 64'(phase), 64'd0);
        check("rst_cfgerr", 64'(cfg_err), 64'd0);
        #1 rst = 1'b1;
        tick;
        check("rst_after_busy", 64'(busy), 64'd0);
        return;
      end
      check($sformatf("data@%0d", e), 64'(data), 64'(q_data[e]));
      if (q_data[e] == HIGH)
        check($sformatf("phase@%0d", e), 64'(phase), 64'(q_ph[e]));
      check($sformatf("rx@%0d", e), 64'(rx_gate), 64'(q_rx[e]));
      check($sformatf("echo@%0d", e), 64'(echo_idx), 64'(q_echo[e]));
      check($sformatf("busy@%0d", e), 64'(busy), 64'(q_busy[e]));
      check($sformatf("done@%0d", e), 64'(done), 64'(q_done[e]));
      if (e < sz - 1 && noise) begin
        start = 1'($urandom);
        tau = $urandom_range(0, 9); tau_l = $urandom_range(0, 9);
        n_echo = 16'($urandom_range(0, 5)); mode = 1'($urandom);
        blank_cyc = $urandom_range(0, 9); delay_reg = $urandom_range(0, 9);
      end else begin
        start = 1'b0;
      end
      if (e + 1 == abort_at) abort = 1'b1;
      tick;
    end
    start = 1'b0;
    check("post_done", 64'(done), 64'd0);
    check("post_busy", 64'(busy), 64'd0);
    check("post_echo_hold", 64'(echo_idx), 64'(n));
  endtask

  task automatic cfg_bad(input int t, input int tl, input int n);
    tau = t; tau_l = tl; n_echo = n; delay_reg = 1; blank_cyc = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("cfgerr_pulse", 64'(cfg_err), 64'd1);
    check("cfgerr_busy", 64'(busy), 64'd0);
    check("cfgerr_data", 64'(data), 64'(LOW));
    tick;
    check("cfgerr_clear", 64'(cfg_err), 64'd0);
    check("cfgerr_busy2", 64'(busy), 64'd0);
    tick;
    check("cfgerr_data2", 64'(data), 64'(LOW));
  endtask

  initial begin
    #3;
    check("reset_data", 64'(data), 64'(LOW));
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_echo", 64'(echo_idx), 64'd0);
    check("reset_rx", 64'(rx_gate), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_cfgerr", 64'(cfg_err), 64'd0);
    check("reset_phase", 64'(phase), 64'd0);
    tick; tick;
    rst = 1'b1;
    tick; tick;

    run_seq(2, 4, 10, 3, 1, 0, -1, -1, 1'b0);
    run_seq(2, 4, 10, 3, 0, 0, -1, -1, 1'b0);
    run_seq(2, 4, 10, 3, 1, 3, -1, -1, 1'b0);
    run_seq(2, 4, 10, 3, 1, 50, -1, -1, 1'b0);
    run_seq(0, 1, 1, 1, 1, 0, -1, -1, 1'b0);
    run_seq(0, 2, 1, 2, 0, 1, -1, -1, 1'b0);

    cfg_bad(4, 10, 0);
    cfg_bad(0, 10, 3);
    cfg_bad(4, 0, 3);

    // start and abort together in IDLE: abort wins
    delay_reg = 1; tau = 2; tau_l = 2; n_echo = 1; blank_cyc = 0;
    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    check("startabort_busy", 64'(busy), 64'd0);
    check("startabort_cfgerr", 64'(cfg_err), 64'd0);
    tick;
    check("startabort_busy2", 64'(busy), 64'd0);

    // abort in the middle of the second 180 (edges 45..52)
    run_seq(2, 4, 10, 3, 1, 0, 47, -1, 1'b0);
    run_seq(2, 4, 10, 3, 1, 2, -1, -1, 1'b0);
    // async reset in the middle of the first inter-180 window
    run_seq(2, 4, 10, 3, 1, 0, -1, 30, 1'b0);
    run_seq(2, 4, 10, 3, 1, 3, -1, -1, 1'b1);

    for (int r = 0; r < 12; r++) begin
      run_seq($urandom_range(0, 5), $urandom_range(1, 4), $urandom_range(1, 6),
              $urandom_range(1, 4), 1'($urandom), $urandom_range(0, 8), -1, -1, 1'b1);
      tick;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
